master_wr_req_tracker: RTL and testbench

Parametrised write-request tracker for the interconnect write path. It holds one sticky write request per master and counts each master's accepted-but-unanswered AW transactions. It releases a master's request only when its last outstanding B response completes. It sits between the master AW inputs and the write arbiter. It extends the fixed three-master request latch with N channels, outstanding-depth tracking, full indication and error flags.

---
 rtl/master_wr_req_tracker.sv | 162 ++++++++++++++++
 tb/tb_master_wr_req_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/master_wr_req_tracker.sv
// master_wr_req_tracker
// Holds one sticky write request per master and counts each master's
// accepted-but-unanswered AW transactions; a master's request is released
// only when its last outstanding B response completes.
//
// Ports
//   sys_clk         clock, all state on rising edge
//   sys_rst         asynchronous active-high reset
//   m_awvalid       per-master write address valid
//   wr_grant        one-hot write grant from arbiter (all-zero = no grant)
//   s_awvalid       granted AW valid toward slave
//   m_awready       slave AW ready
//   m_bvalid        slave B valid
//   s_bready        granted master B ready
//   wr_reg_flag     burst-continuation flag, masks the B handshake
//   wr_req          registered request per master, to arbiter
//   wr_full         registered, master count == MAX_OUTSTANDING
//   wr_cnt          registered outstanding counts, master i at [i*CW +: CW]
//   wr_state_refre  combinational arbiter-refresh strobe
//   wr_err          sticky errors: [0] overflow, [1] underflow / bad grant
module master_wr_req_tracker #(
    parameter int unsigned NUM_MASTERS     = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_MASTERS-1:0]    m_awvalid,
    input  logic [NUM_MASTERS-1:0]    wr_grant,
    input  logic                      s_awvalid,
    input  logic                      m_awready,
    input  logic                      m_bvalid,
    input  logic                      s_bready,
    input  logic                      wr_reg_flag,
    output logic [NUM_MASTERS-1:0]    wr_req,
    output logic [NUM_MASTERS-1:0]    wr_full,
    output logic [NUM_MASTERS*CW-1:0] wr_cnt,
    output logic                      wr_state_refre,
    output logic [1:0]                wr_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACTIVE = 2'd2
    } st_e;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    st_e              state_q   [NUM_MASTERS];
    st_e              state_nxt [NUM_MASTERS];
    logic [CW-1:0]    cnt_q     [NUM_MASTERS];
    logic [CW-1:0]    cnt_nxt   [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] req_nxt;
    logic [NUM_MASTERS-1:0] full_nxt;
    logic [1:0]       err_nxt;

    logic                   grant_ok;
    logic                   aw_hs;
    logic                   b_hs;
    logic                   bad_grant;
    logic [NUM_MASTERS-1:0] aw_sel;
    logic [NUM_MASTERS-1:0] b_sel;
    logic                   ovf;
    logic                   unf;

    // Handshake qualification shared by all masters
    always_comb begin
        grant_ok  = (wr_grant != '0) &&
                    ((wr_grant & (wr_grant - NUM_MASTERS'(1))) == '0);
        aw_hs     = s_awvalid && m_awready;
        b_hs      = m_bvalid && s_bready && !wr_reg_flag;
        bad_grant = (aw_hs || b_hs) && (wr_grant != '0) && !grant_ok;
        aw_sel    = {NUM_MASTERS{aw_hs && grant_ok}} & wr_grant;
        b_sel     = {NUM_MASTERS{b_hs && grant_ok}} & wr_grant;
    end

    // Refresh strobe depends only on the handshakes, never on the counters
    assign wr_state_refre = b_hs && !aw_hs && grant_ok;

    // Per-master next-state, counter and error logic
    always_comb begin
        ovf = 1'b0;
        unf = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (aw_sel[i]) begin
                        state_nxt[i] = ST_ACTIVE;
                        cnt_nxt[i]   = CNT_ONE;
                    end else if (m_awvalid[i]) begin
                        state_nxt[i] = ST_PEND;
                    end
                    if (b_sel[i]) unf = 1'b1;
                end
                ST_PEND: begin
                    // request is sticky: only an AW handshake moves on
                    if (aw_sel[i]) begin
                        state_nxt[i] = ST_ACTIVE;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                    if (b_sel[i]) unf = 1'b1;
                end
                ST_ACTIVE: begin
                    if (aw_sel[i] && b_sel[i]) begin
                        cnt_nxt[i] = cnt_q[i];
                    end else if (aw_sel[i]) begin
                        if (cnt_q[i] == CNT_MAX) ovf = 1'b1;
                        else                     cnt_nxt[i] = cnt_q[i] + CNT_ONE;
                    end else if (b_sel[i]) begin
                        if (cnt_q[i] == CNT_ONE) begin
                            cnt_nxt[i]   = '0;
                            state_nxt[i] = m_awvalid[i] ? ST_PEND : ST_IDLE;
                        end else begin
                            cnt_nxt[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
            req_nxt[i]  = (state_nxt[i] != ST_IDLE);
            full_nxt[i] = (cnt_nxt[i] == CNT_MAX);
        end
        err_nxt = wr_err | {unf | bad_grant, ovf};
    end

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            wr_req  <= '0;
            wr_full <= '0;
            wr_err  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
            wr_req  <= req_nxt;
            wr_full <= full_nxt;
            wr_err  <= err_nxt;
        end
    end

    // Flatten the counter registers onto the output bus
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            wr_cnt[i*CW +: CW] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_master_wr_req_tracker.sv
// Scoreboard bench for master_wr_req_tracker (NUM_MASTERS=3, MAX_OUTSTANDING=4).
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_master_wr_req_tracker;

    localparam int unsigned N  = 3;
    localparam int unsigned M  = 4;
    localparam int unsigned CW = 3;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b0;
    logic [N-1:0]   m_awvalid = '0;
    logic [N-1:0]   wr_grant = '0;
    logic           s_awvalid = 1'b0;
    logic           m_awready = 1'b0;
    logic           m_bvalid = 1'b0;
    logic           s_bready = 1'b0;
    logic           wr_reg_flag = 1'b0;
    logic [N-1:0]   wr_req;
    logic [N-1:0]   wr_full;
    logic [N*CW-1:0] wr_cnt;
    logic           wr_state_refre;
    logic [1:0]     wr_err;

    master_wr_req_tracker #(
        .NUM_MASTERS    (N),
        .MAX_OUTSTANDING(M)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .m_awvalid      (m_awvalid),
        .wr_grant       (wr_grant),
        .s_awvalid      (s_awvalid),
        .m_awready      (m_awready),
        .m_bvalid       (m_bvalid),
        .s_bready       (s_bready),
        .wr_reg_flag    (wr_reg_flag),
        .wr_req         (wr_req),
        .wr_full        (wr_full),
        .wr_cnt         (wr_cnt),
        .wr_state_refre (wr_state_refre),
        .wr_err         (wr_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        string         name;
        logic [N-1:0]  req;
        logic [N-1:0]  full;
        logic [N*CW-1:0] cnt;
        logic [1:0]    err;
        logic          refre;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, exp);
        end
    endtask

    // Monitor: each clock edge or asynchronous reset assertion consumes one entry.
    // The strobe is sampled at the trigger (inputs still applied); registered
    // outputs are sampled 1 time unit later.
    initial begin
        logic refre_s;
        exp_t e;
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            refre_s = wr_state_refre;
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.name, "refre", 32'(refre_s), 32'(e.refre));
                cmp(e.name, "req",   32'(wr_req),  32'(e.req));
                cmp(e.name, "full",  32'(wr_full), 32'(e.full));
                cmp(e.name, "cnt",   32'(wr_cnt),  32'(e.cnt));
                cmp(e.name, "err",   32'(wr_err),  32'(e.err));
            end
        end
    end

    function automatic exp_t mk(input string name, input logic [N-1:0] req,
                                input int c0, input int c1, input int c2,
                                input logic [1:0] err, input logic refre);
        exp_t e;
        e.name  = name;
        e.req   = req;
        e.cnt   = {3'(c2), 3'(c1), 3'(c0)};
        e.full  = {c2 == int'(M), c1 == int'(M), c0 == int'(M)};
        e.err   = err;
        e.refre = refre;
        return e;
    endfunction

    // One cycle of stimulus: drive on the falling edge, push the expectation
    // for the outputs seen after the next rising edge.
    task automatic step(input string name, input logic [N-1:0] awv,
                        input logic [N-1:0] gnt, input logic aw, input logic b,
                        input logic flag, input logic [N-1:0] req,
                        input int c0, input int c1, input int c2,
                        input logic [1:0] err, input logic refre);
        @(negedge sys_clk);
        m_awvalid   = awv;
        wr_grant    = gnt;
        s_awvalid   = aw;
        m_awready   = aw;
        m_bvalid    = b;
        s_bready    = b;
        wr_reg_flag = flag;
        sb_q.push_back(mk(name, req, c0, c1, c2, err, refre));
    endtask

    initial begin
        sys_rst = 1'b1;
        // reset then idle
        step("rst_a", 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
        step("rst_b", 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
        step("rst_c", 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // single transaction on master 1
        step("m1_pulse", 3'b010, 3'b000, 0, 0, 0, 3'b010, 0, 0, 0, 2'b00, 0);
        step("m1_aw",    3'b000, 3'b010, 1, 0, 0, 3'b010, 0, 1, 0, 2'b00, 0);
        step("m1_b",     3'b000, 3'b010, 0, 1, 0, 3'b000, 0, 0, 0, 2'b00, 1);
        step("m1_idle",  3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);

        // outstanding depth on master 0, overflow on the fifth AW
        step("m0_aw1", 3'b001, 3'b001, 1, 0, 0, 3'b001, 1, 0, 0, 2'b00, 0);
        step("m0_aw2", 3'b001, 3'b001, 1, 0, 0, 3'b001, 2, 0, 0, 2'b00, 0);
        step("m0_aw3", 3'b001, 3'b001, 1, 0, 0, 3'b001, 3, 0, 0, 2'b00, 0);
        step("m0_aw4", 3'b001, 3'b001, 1, 0, 0, 3'b001, 4, 0, 0, 2'b00, 0);
        step("m0_ovf", 3'b001, 3'b001, 1, 0, 0, 3'b001, 4, 0, 0, 2'b01, 0);
        step("m0_b1",  3'b000, 3'b001, 0, 1, 0, 3'b001, 3, 0, 0, 2'b01, 1);
        step("m0_b2",  3'b000, 3'b001, 0, 1, 0, 3'b001, 2, 0, 0, 2'b01, 1);
        step("m0_b3",  3'b000, 3'b001, 0, 1, 0, 3'b001, 1, 0, 0, 2'b01, 1);
        step("m0_b4",  3'b000, 3'b001, 0, 1, 0, 3'b000, 0, 0, 0, 2'b01, 1);

        // simultaneous AW+B and flag gating on master 2
        step("m2_aw",   3'b000, 3'b100, 1, 0, 0, 3'b100, 0, 0, 1, 2'b01, 0);
        step("m2_awb",  3'b000, 3'b100, 1, 1, 0, 3'b100, 0, 0, 1, 2'b01, 0);
        step("m2_flag", 3'b000, 3'b100, 0, 1, 1, 3'b100, 0, 0, 1, 2'b01, 0);
        step("m2_b",    3'b000, 3'b100, 0, 1, 0, 3'b000, 0, 0, 0, 2'b01, 1);

        // final B with m_awvalid high keeps the request without a gap
        step("m2_aw2",   3'b000, 3'b100, 1, 0, 0, 3'b100, 0, 0, 1, 2'b01, 0);
        step("m2_b_awv", 3'b100, 3'b100, 0, 1, 0, 3'b100, 0, 0, 0, 2'b01, 1);
        step("m2_stick", 3'b000, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0, 2'b01, 0);

        // B to an idle master is an underflow; strobe still follows handshakes
        step("m1_unf", 3'b000, 3'b010, 0, 1, 0, 3'b100, 0, 0, 0, 2'b11, 1);

        // build up counts, then reset asynchronously between edges
        step("pre_a", 3'b000, 3'b001, 1, 0, 0, 3'b101, 1, 0, 0, 2'b11, 0);
        step("pre_b", 3'b000, 3'b001, 1, 0, 0, 3'b101, 2, 0, 0, 2'b11, 0);
        step("pre_c", 3'b000, 3'b001, 1, 0, 0, 3'b101, 3, 0, 0, 2'b11, 0);
        step("pre_d", 3'b000, 3'b010, 1, 0, 0, 3'b111, 3, 1, 0, 2'b11, 0);
        step("pre_e", 3'b000, 3'b010, 1, 0, 0, 3'b111, 3, 2, 0, 2'b11, 0);
        step("async_rst", 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b00, 0);
        #2;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // bad grant and all-zero grant
        step("bad_aw",  3'b000, 3'b011, 1, 0, 0, 3'b000, 0, 0, 0, 2'b10, 0);
        step("bad_b",   3'b000, 3'b011, 0, 1, 0, 3'b000, 0, 0, 0, 2'b10, 0);
        step("zero_aw", 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0, 0, 2'b10, 0);
        step("end_idle", 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 2'b10, 0);

        repeat (3) @(negedge sys_clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
